matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream feeder for the 3x3 matrix subtractor stage. It accepts a serial stream of 16-bit words over a valid/ready handshake and assembles each frame into two complete 3x3 operand matrices: minuend A, then subtrahend B. It presents both matrices in parallel to the subtractor, holding them stable until the downstream stage accepts them. It also checks frame framing and flags malformed frames.

## Interface
Parameters:
- ELEM_W, 16, element width in bits; must match the subtractor element width.
- N_ELEM, 9, elements per matrix; fixed at 3x3.

Ports (reset is asynchronous and active-high; single clock):
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort; discards the partial frame and any held frame
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a word this cycle
- in_data  input  ELEM_W  stream word
- in_last  input  1  marks the final word (word 17) of a frame
- out_valid  output  1  a_mat and b_mat hold a complete frame
- out_ready  input  1  downstream accepts the frame
- a_mat  output  N_ELEM*ELEM_W  minuend; element k (k = 0..8, row-major, maps to subtractor elements a..i) at bits [16k+15:16k]
- b_mat  output  N_ELEM*ELEM_W  subtrahend, same packing
- err  output  1  one-cycle pulse on a framing error

## Operation
- A word is accepted when in_valid and in_ready are both high. A frame is accepted when out_valid and out_ready are both high.
- States:
  - LOAD_A: idx 0..8. Each accepted word is written to A[idx].
  - LOAD_B: idx 9..17. Each accepted word is written to B[idx-9].
  - HOLD: the frame is complete and out_valid=1.
- idx is a 5-bit counter, cleared on entering LOAD_A.
- Transitions:
  - LOAD_A to LOAD_B on accepting idx 8.
  - LOAD_B to HOLD on accepting idx 17.
  - HOLD to LOAD_A on frame acceptance.
- in_ready is 1 in LOAD_A and LOAD_B, and 0 in HOLD (base build).
- Framing rules:
  - in_last with idx < 17: the word is consumed, the frame is dropped, err pulses, and the next state is LOAD_A.
  - idx 17 without in_last: the frame completes normally, and err pulses once.
- clr takes priority over all handshakes. The next state is LOAD_A, idx becomes 0, out_valid becomes 0, and err is not pulsed. Any word presented in the clr cycle is not accepted (in_ready=0 that cycle).
- Matrix registers are not cleared on reset or clr. Their contents are don't-care while out_valid=0.
- a_mat and b_mat are stable whenever out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=0 while rst is asserted, then 1 from the first cycle after deassertion. out_valid=0, err=0, state=LOAD_A, idx=0.
- out_valid rises in the cycle after word 17 is accepted. Minimum frame latency is 18 accepted words plus 1 cycle.
- When out_ready is held high, throughput is one frame per 19 cycles in the base build.
- err rises in the cycle after the offending word is accepted and lasts exactly one cycle.
- rst asserted mid-frame discards everything immediately, asynchronously.

## Configuration
- MATLOAD_PREFETCH_EN:
  - Defined: a shadow frame buffer is added. In HOLD, in_ready stays 1 and words fill the shadow buffer; in_ready drops only when the shadow buffer is complete and the output frame is still unaccepted.
  - On frame acceptance with a complete shadow, the shadow moves to the output in the same edge, so out_valid stays 1 with the new data. Sustained throughput is one frame per 18 cycles.
  - clr discards both buffers. Framing errors in the shadow frame drop only the shadow frame.
  - Undefined: single buffer only, behaviour as above.

## Structure
- Shared package matload_pkg contains ELEM_W, N_ELEM, FRAME_LEN=18, the state enum (LOAD_A, LOAD_B, HOLD), and the idx width.
- Sub-module matload_frame_buf holds one 18 x ELEM_W register frame with a write port (idx, data, we) and flat a_mat/b_mat outputs. It is instantiated once, or twice under MATLOAD_PREFETCH_EN.

## Test plan
- Basic frame: stream words 1..18, with in_last on 18, and out_ready=1. Required: a_mat elements 0..8 = 1..9, b_mat elements 0..8 = 10..18; out_valid high 1 cycle after word 18; err=0.
- Backpressure: keep out_ready=0 for 10 cycles after a frame completes. Required: in_ready=0, while a_mat and b_mat stay constant and out_valid=1 throughout; raising out_ready returns the block to LOAD_A next cycle.
- Early in_last: assert in_last on word 5. Required: err pulses for 1 cycle, no out_valid; the next 18 words form a correct frame.
- Missing in_last: send 18 words with in_last=0. Required: out_valid=1 with correct data and a single err pulse.
- clr mid-frame: send 12 words, assert clr, then send a fresh 18-word frame (0x8000..0x8011). Required: the output equals the fresh frame only, and err=0.
- Async reset: assert rst between clock edges while in HOLD. Required: out_valid=0 immediately. With MATLOAD_PREFETCH_EN, repeat back-to-back frames and require no out_valid gap.

Source files
------------

// File: rtl/matload_pkg.sv
// Shared constants and state encoding for the matrix operand loader.
package matload_pkg;

    localparam int ELEM_W    = 16;
    localparam int N_ELEM    = 9;
    localparam int FRAME_LEN = 18;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/matload_frame_buf.sv
// One frame of operand storage: A in words 0..N_ELEM-1, B after it.
// The ld port replaces the whole frame in one edge and wins over we.
module matload_frame_buf
    import matload_pkg::*;
#(
    parameter int ELEM_W = matload_pkg::ELEM_W,
    parameter int N_ELEM = matload_pkg::N_ELEM
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [IDX_W-1:0]             idx,
    input  logic [ELEM_W-1:0]            data,
    input  logic                         ld,
    input  logic [2*N_ELEM*ELEM_W-1:0]   ld_frame,
    output logic [N_ELEM*ELEM_W-1:0]     a_mat,
    output logic [N_ELEM*ELEM_W-1:0]     b_mat
);

    localparam int FL = 2 * N_ELEM;

    // Data storage only, so no reset.
    logic [ELEM_W-1:0] mem [FL];

    always_ff @(posedge clk) begin
        if (ld) begin
            for (int k = 0; k < FL; k++) begin
                mem[k] <= ld_frame[k*ELEM_W +: ELEM_W];
            end
        end else if (we) begin
            mem[idx] <= data;
        end
    end

    for (genvar k = 0; k < N_ELEM; k++) begin : g_out
        assign a_mat[k*ELEM_W +: ELEM_W] = mem[k];
        assign b_mat[k*ELEM_W +: ELEM_W] = mem[k+N_ELEM];
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel loader that assembles 18-word frames into the A/B operands of the 3x3 subtractor.
// Optional MATLOAD_PREFETCH_EN adds a shadow frame that fills while the output frame is held.
//
// state  | meaning
// LOAD_A | filling minuend, idx 0..8
// LOAD_B | filling subtrahend, idx 9..17
// HOLD   | complete frame presented, out_valid=1
module matrix_operand_loader
    import matload_pkg::*;
#(
    parameter int ELEM_W = matload_pkg::ELEM_W,
    parameter int N_ELEM = matload_pkg::N_ELEM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_ELEM*ELEM_W-1:0]  a_mat,
    output logic [N_ELEM*ELEM_W-1:0]  b_mat,
    output logic                      err
);

    localparam int FW = 2 * N_ELEM * ELEM_W;
    localparam logic [IDX_W-1:0] A_END = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] F_END = IDX_W'(2 * N_ELEM - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             acc;
    logic             main_we, main_ld;
    logic [FW-1:0]    main_ld_frame;

`ifdef MATLOAD_PREFETCH_EN
    logic [IDX_W-1:0]         sidx_q, sidx_d, sidx_n;
    logic                     sfull_q, sfull_d, sfull_n;
    logic                     sh_we;
    logic [N_ELEM*ELEM_W-1:0] sh_a, sh_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            err_q   <= 1'b0;
`ifdef MATLOAD_PREFETCH_EN
            sidx_q  <= '0;
            sfull_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef MATLOAD_PREFETCH_EN
            sidx_q  <= sidx_d;
            sfull_q <= sfull_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        main_we = 1'b0;
        main_ld = 1'b0;
`ifdef MATLOAD_PREFETCH_EN
        sidx_d  = sidx_q;
        sfull_d = sfull_q;
        sidx_n  = sidx_q;
        sfull_n = sfull_q;
        sh_we   = 1'b0;
        in_ready = !rst && !clr && ((state_q != HOLD) || !sfull_q);
`else
        in_ready = !rst && !clr && (state_q != HOLD);
`endif
        acc = in_valid && in_ready;

        if (clr) begin
            state_d = LOAD_A;
            idx_d   = '0;
`ifdef MATLOAD_PREFETCH_EN
            sidx_d  = '0;
            sfull_d = 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD_A, LOAD_B: begin
                    if (acc) begin
                        main_we = 1'b1;
                        if (idx_q == F_END) begin
                            state_d = HOLD;
                            idx_d   = '0;
                            err_d   = !in_last;
                        end else if (in_last) begin
                            state_d = LOAD_A;
                            idx_d   = '0;
                            err_d   = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            if (idx_q == A_END) state_d = LOAD_B;
                        end
                    end
                end
                HOLD: begin
`ifdef MATLOAD_PREFETCH_EN
                    if (acc) begin
                        sh_we = 1'b1;
                        if (sidx_q == F_END) begin
                            sfull_n = 1'b1;
                            sidx_n  = '0;
                            err_d   = !in_last;
                        end else if (in_last) begin
                            sidx_n = '0;
                            err_d  = 1'b1;
                        end else begin
                            sidx_n = sidx_q + 1'b1;
                        end
                    end
                    // On acceptance the shadow (including this cycle's word) becomes the output frame;
                    // a partial shadow resumes loading from where it stopped.
                    if (out_ready) begin
                        sidx_d  = '0;
                        sfull_d = 1'b0;
                        if (sfull_n) begin
                            main_ld = 1'b1;
                        end else if (sidx_n != '0) begin
                            main_ld = 1'b1;
                            idx_d   = sidx_n;
                            state_d = (sidx_n > A_END) ? LOAD_B : LOAD_A;
                        end else begin
                            state_d = LOAD_A;
                            idx_d   = '0;
                        end
                    end else begin
                        sidx_d  = sidx_n;
                        sfull_d = sfull_n;
                    end
`else
                    if (out_ready) begin
                        state_d = LOAD_A;
                        idx_d   = '0;
                    end
`endif
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

`ifdef MATLOAD_PREFETCH_EN
    always_comb begin
        main_ld_frame = {sh_b, sh_a};
        if (sh_we) main_ld_frame[int'(sidx_q)*ELEM_W +: ELEM_W] = in_data;
    end

    matload_frame_buf #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_shadow (
        .clk      (clk),
        .we       (sh_we),
        .idx      (sidx_q),
        .data     (in_data),
        .ld       (1'b0),
        .ld_frame ({FW{1'b0}}),
        .a_mat    (sh_a),
        .b_mat    (sh_b)
    );
`else
    assign main_ld_frame = '0;
`endif

    matload_frame_buf #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_main (
        .clk      (clk),
        .we       (main_we),
        .idx      (idx_q),
        .data     (in_data),
        .ld       (main_ld),
        .ld_frame (main_ld_frame),
        .a_mat    (a_mat),
        .b_mat    (b_mat)
    );

    assign out_valid = (state_q == HOLD);
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader with a frame scoreboard; follows MATLOAD_PREFETCH_EN when defined.
module tb_matrix_operand_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [143:0] a_mat, b_mat;
    logic         err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    logic [287:0] exp_q[$];

    matrix_operand_loader #(.ELEM_W(16), .N_ELEM(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [287:0] mk(input logic [15:0] base);
        logic [287:0] f;
        f = '0;
        for (int k = 0; k < 18; k++) f[k*16 +: 16] = base + 16'(k);
        return f;
    endfunction

    // Scoreboard pop on every accepted output frame.
    always @(negedge clk) begin
        cyc++;
        if (err) err_cnt++;
        if (!rst && out_valid && out_ready) begin
            prev_pulse = last_pulse;
            last_pulse = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected: observed frame %0h, expected none", {b_mat, a_mat});
            end
            if (exp_q.size() != 0) check("sb_frame", {b_mat, a_mat}, exp_q.pop_front());
        end
    end

    task automatic send_word(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            miscompares++;
            $error("FAIL accept_timeout: observed in_ready=0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_last = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base, input int last_at, input bit push);
        if (push) exp_q.push_back(mk(base));
        for (int k = 0; k < 18; k++) send_word(base + 16'(k), (k == last_at));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [287:0] held;

        // reset
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // basic frame
        out_ready = 1'b1;
        send_frame(16'd1, 17, 1'b1);
        idle();
        @(negedge clk);
        check("basic_out_valid", out_valid, 1'b1);
        check("basic_err", err, 1'b0);
        @(posedge clk);
        #1;

        // backpressure
        out_ready = 1'b0;
        send_frame(16'd100, 17, 1'b1);
        idle();
        held = mk(16'd100);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_frame", {b_mat, a_mat}, held);
`ifdef MATLOAD_PREFETCH_EN
            check("bp_in_ready", in_ready, 1'b1);
`else
            check("bp_in_ready", in_ready, 1'b0);
`endif
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // early in_last on word 5
        for (int k = 0; k < 5; k++) send_word(16'h0050 + 16'(k), (k == 4));
        idle();
        @(negedge clk);
        check("early_err_hi", err, 1'b1);
        check("early_no_valid", out_valid, 1'b0);
        @(negedge clk);
        check("early_err_lo", err, 1'b0);
        @(posedge clk);
        #1;
        send_frame(16'd200, 17, 1'b1);
        idle();
        @(negedge clk);
        check("early_next_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;

        // missing in_last
        e0 = err_cnt;
        send_frame(16'd400, -1, 1'b1);
        idle();
        @(negedge clk);
        check("miss_out_valid", out_valid, 1'b1);
        check("miss_err_hi", err, 1'b1);
        @(negedge clk);
        check("miss_err_lo", err, 1'b0);
        @(posedge clk);
        #1;
        check("miss_err_count", 288'(err_cnt - e0), 288'(1));

        // clr mid-frame
        e0 = err_cnt;
        for (int k = 0; k < 12; k++) send_word(16'd300 + 16'(k), 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hdead;
        clr      = 1'b1;
        @(negedge clk);
        check("clr_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        idle();
        send_frame(16'h8000, 17, 1'b1);
        idle();
        @(negedge clk);
        check("clr_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        check("clr_no_err", 288'(err_cnt - e0), 288'(0));

        // async reset while holding
        out_ready = 1'b0;
        send_frame(16'd500, 17, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst_after_valid", out_valid, 1'b0);
        check("arst_after_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // sustained streaming cadence
        send_frame(16'd600, 17, 1'b1);
        send_frame(16'd700, 17, 1'b1);
        send_frame(16'd800, 17, 1'b1);
        idle();
        repeat (3) @(negedge clk);
`ifdef MATLOAD_PREFETCH_EN
        check("stream_period", 288'(last_pulse - prev_pulse), 288'(18));
`else
        check("stream_period", 288'(last_pulse - prev_pulse), 288'(19));
`endif
        @(posedge clk);
        #1;

`ifdef MATLOAD_PREFETCH_EN
        // shadow frame handed over with no out_valid gap
        out_ready = 1'b0;
        send_frame(16'h1000, 17, 1'b1);
        send_frame(16'h2000, 17, 1'b1);
        idle();
        @(negedge clk);
        check("pf_full_in_ready", in_ready, 1'b0);
        check("pf_first_frame", {b_mat, a_mat}, mk(16'h1000));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("pf_no_gap", out_valid, 1'b1);
        check("pf_second_frame", {b_mat, a_mat}, mk(16'h2000));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pf_drained", out_valid, 1'b0);
        @(posedge clk);
        #1;
`endif

        check("sb_drain", 288'(exp_q.size()), 288'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
